mux_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that drives the select of the 2:1 NoC output mux (`mux`). It watches the valid and flit-type fields of both mux inputs, locks the mux onto one input from HEAD flit to TAIL flit (wormhole), and returns a per-input grant so each source holds a flit until it is accepted. Both inputs requesting at once alternate fairly. A flit-count watchdog forces release if a packet never delivers its TAIL.

---
 rtl/mux_pkt_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux_pkt_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter steering the select of a 2:1 NoC output mux.
// Locks the mux onto one input from HEAD to TAIL, with a flit-count watchdog.
module mux_pkt_arbiter #(
  parameter int                TYPEW  = 2,
  parameter logic [TYPEW-1:0]  T_NONE = 2'b00,
  parameter logic [TYPEW-1:0]  T_HEAD = 2'b01,
  parameter logic [TYPEW-1:0]  T_DATA = 2'b10,
  parameter logic [TYPEW-1:0]  T_TAIL = 2'b11,
  parameter int                PORTW  = 5,
  parameter int                MAXLEN = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             oready,
  output logic [PORTW-1:0] sel,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             busy,
  output logic             err
);

  localparam int CNTW = $clog2(MAXLEN + 1);
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(MAXLEN - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state, state_nxt;
  logic            pri, pri_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            err_nxt;

  logic [1:0] kind_0, kind_1;
  logic       hreq_0, hreq_1, tail_0, tail_1;

  // Returns {is_tail, is_head}; NONE and DATA flits carry no framing meaning.
  function automatic logic [1:0] decode(input logic [TYPEW-1:0] t);
    case (t)
      T_HEAD:         decode = 2'b01;
      T_TAIL:         decode = 2'b10;
      T_NONE, T_DATA: decode = 2'b00;
      default:        decode = 2'b00;
    endcase
  endfunction

  assign kind_0 = decode(itype_0);
  assign kind_1 = decode(itype_1);
  assign hreq_0 = ivalid_0 & kind_0[0];
  assign hreq_1 = ivalid_1 & kind_1[0];
  assign tail_0 = kind_0[1];
  assign tail_1 = kind_1[1];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      pri   <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pri   <= pri_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // A TAIL always wins over the watchdog, so a packet of exactly MAXLEN flits is legal.
  always_comb begin
    state_nxt = state;
    pri_nxt   = pri;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (hreq_0 && (!hreq_1 || !pri)) begin
          state_nxt = OWN0;
          cnt_nxt   = '0;
        end else if (hreq_1) begin
          state_nxt = OWN1;
          cnt_nxt   = '0;
        end
      end
      OWN0: begin
        if (gnt_0) begin
          cnt_nxt = cnt + CNTW'(1);
          if (tail_0) begin
            pri_nxt = 1'b1;
            if (hreq_1) begin
              state_nxt = OWN1;
              cnt_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else if (cnt == CNT_LIMIT) begin
            err_nxt   = 1'b1;
            pri_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      OWN1: begin
        if (gnt_1) begin
          cnt_nxt = cnt + CNTW'(1);
          if (tail_1) begin
            pri_nxt = 1'b0;
            if (hreq_0) begin
              state_nxt = OWN0;
              cnt_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else if (cnt == CNT_LIMIT) begin
            err_nxt   = 1'b1;
            pri_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel   = '0;
    busy  = 1'b0;
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    case (state)
      OWN0: begin
        sel   = PORTW'(1);
        busy  = 1'b1;
        gnt_0 = ivalid_0 & oready;
      end
      OWN1: begin
        sel   = PORTW'(2);
        busy  = 1'b1;
        gnt_1 = ivalid_1 & oready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Scoreboard bench for mux_pkt_arbiter: directed per-cycle vectors queue the
// expected grant/err events, and a negedge monitor matches them cycle by cycle.
module tb_mux_pkt_arbiter;

  localparam logic [1:0] TN = 2'b00;
  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TD = 2'b10;
  localparam logic [1:0] TT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       ivalid_0 = 1'b0, ivalid_1 = 1'b0, oready = 1'b0;
  logic [1:0] itype_0 = TN, itype_1 = TN;
  logic [4:0] sel;
  logic       gnt_0, gnt_1, busy, err;

  typedef struct {
    int         cyc;
    logic       g0;
    logic       g1;
    logic [4:0] sel;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mux_pkt_arbiter #(.MAXLEN(32)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .oready(oready), .sel(sel),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any grant or err pulse must match the head of the queue for this exact cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("[TB] FAIL missing_event cycle=%0d actual=none required g0=%0b g1=%0b sel=%b err=%0b",
               exp_q[0].cyc, exp_q[0].g0, exp_q[0].g1, exp_q[0].sel, exp_q[0].err);
      void'(exp_q.pop_front());
    end
    if (gnt_0 || gnt_1 || err) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        if ({gnt_0, gnt_1, sel, err} !== {mon_e.g0, mon_e.g1, mon_e.sel, mon_e.err}) begin
          failures++;
          $display("[TB] FAIL event cycle=%0d actual g0=%0b g1=%0b sel=%b err=%0b required g0=%0b g1=%0b sel=%b err=%0b",
                   cyc, gnt_0, gnt_1, sel, err, mon_e.g0, mon_e.g1, mon_e.sel, mon_e.err);
        end
      end else begin
        failures++;
        $display("[TB] FAIL unexpected_event cycle=%0d actual g0=%0b g1=%0b sel=%b err=%0b required none",
                 cyc, gnt_0, gnt_1, sel, err);
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [1:0] t0,
                               input logic v1, input logic [1:0] t1,
                               input logic rdy, input logic eg0,
                               input logic eg1, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    ivalid_0 = v0;
    itype_0  = t0;
    ivalid_1 = v1;
    itype_1  = t1;
    oready   = rdy;
    if (eg0 || eg1 || eerr) begin
      e.cyc = cyc;
      e.g0  = eg0;
      e.g1  = eg1;
      e.sel = eg0 ? 5'b00001 : (eg1 ? 5'b00010 : 5'b00000);
      e.err = eerr;
      exp_q.push_back(e);
    end
  endtask

  task automatic compareNow(input string name, input logic [4:0] esel,
                            input logic ebusy, input logic eerr);
    checks++;
    if ({sel, busy, err, gnt_0, gnt_1} !== {esel, ebusy, eerr, 2'b00}) begin
      failures++;
      $display("[TB] FAIL %s actual sel=%b busy=%0b err=%0b g0=%0b g1=%0b required sel=%b busy=%0b err=%0b g0=0 g1=0",
               name, sel, busy, err, gnt_0, gnt_1, esel, ebusy, eerr);
    end
  endtask

  task automatic checkOutput(input string name, input logic [4:0] esel,
                             input logic ebusy, input logic eerr);
    @(negedge clk);
    compareNow(name, esel, ebusy, eerr);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout cycle=%0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] typ;
    int         own;

    repeat (2) @(posedge clk);
    #1;
    compareNow("reset_state", 5'b00000, 1'b0, 1'b0);
    @(negedge clk);
    rst_ = 1'b1;

    // Single source: input 1, HEAD + 20 DATA + TAIL.
    applyStimulus(0, TN, 1, TH, 1, 0, 0, 0);
    applyStimulus(0, TN, 1, TH, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, TN, 1, TD, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TT, 1, 0, 1, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("single_release", 5'b00000, 1'b0, 1'b0);

    // Simultaneous HEADs with pri=0: input 0 first, then input 1 with no bubble.
    applyStimulus(1, TH, 1, TH, 1, 0, 0, 0);
    applyStimulus(1, TH, 1, TH, 1, 1, 0, 0);
    applyStimulus(1, TD, 1, TH, 1, 1, 0, 0);
    applyStimulus(1, TT, 1, TH, 1, 1, 0, 0);
    applyStimulus(0, TN, 1, TH, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TD, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TT, 1, 0, 1, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("both_release", 5'b00000, 1'b0, 1'b0);

    // Fairness: 4 packets per input, 3 flits each, owners alternate every 3 cycles.
    applyStimulus(1, TH, 1, TH, 1, 0, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      own = ((c - 1) / 3) % 2;
      typ = ((c - 1) % 3 == 0) ? TH : (((c - 1) % 3 == 1) ? TD : TT);
      if (own == 0) applyStimulus(1, typ, 1, TH, 1, 1, 0, 0);
      else          applyStimulus(c <= 18, TH, 1, typ, 1, 0, 1, 0);
    end
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("fair_release", 5'b00000, 1'b0, 1'b0);

    // Backpressure: 3 cycles oready low, then 2 cycles ivalid_0 low.
    applyStimulus(1, TH, 0, TN, 1, 0, 0, 0);
    applyStimulus(1, TH, 0, TN, 1, 1, 0, 0);
    applyStimulus(1, TD, 0, TN, 1, 1, 0, 0);
    applyStimulus(1, TD, 0, TN, 0, 0, 0, 0);
    checkOutput("stall_ready", 5'b00001, 1'b1, 1'b0);
    applyStimulus(1, TD, 0, TN, 0, 0, 0, 0);
    applyStimulus(1, TD, 0, TN, 0, 0, 0, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("stall_valid", 5'b00001, 1'b1, 1'b0);
    applyStimulus(1, TD, 0, TN, 1, 1, 0, 0);
    applyStimulus(1, TD, 0, TN, 1, 1, 0, 0);
    applyStimulus(1, TT, 0, TN, 1, 1, 0, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("stall_release", 5'b00000, 1'b0, 1'b0);

    // Watchdog: input 0 never sends TAIL; the 32nd transfer trips err, input 1 takes over.
    applyStimulus(1, TH, 0, TN, 1, 0, 0, 0);
    applyStimulus(1, TH, 1, TH, 1, 1, 0, 0);
    for (int i = 0; i < 31; i++) applyStimulus(1, TD, 1, TH, 1, 1, 0, 0);
    applyStimulus(1, TD, 1, TH, 1, 0, 0, 1);
    applyStimulus(1, TD, 1, TH, 1, 0, 1, 0);
    applyStimulus(1, TD, 1, TD, 1, 0, 1, 0);
    applyStimulus(1, TD, 1, TT, 1, 0, 1, 0);
    applyStimulus(1, TD, 0, TN, 1, 0, 0, 0);
    checkOutput("wd_stray_data", 5'b00000, 1'b0, 1'b0);

    // Exactly MAXLEN flits ending in TAIL is legal: no err.
    applyStimulus(1, TH, 0, TN, 1, 0, 0, 0);
    applyStimulus(1, TH, 0, TN, 1, 1, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(1, TD, 0, TN, 1, 1, 0, 0);
    applyStimulus(1, TT, 0, TN, 1, 1, 0, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("maxlen_tail_noerr", 5'b00000, 1'b0, 1'b0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("maxlen_tail_noerr2", 5'b00000, 1'b0, 1'b0);

    // Reset during OWN1, then stray DATA/TAIL, then simultaneous HEADs (pri back to 0).
    applyStimulus(0, TN, 1, TH, 1, 0, 0, 0);
    applyStimulus(0, TN, 1, TH, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TD, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TD, 0, 0, 0, 0);
    #2;
    rst_ = 1'b0;
    #1;
    compareNow("reset_midpkt", 5'b00000, 1'b0, 1'b0);
    applyStimulus(0, TN, 1, TD, 1, 0, 0, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    @(negedge clk);
    rst_ = 1'b1;
    applyStimulus(0, TN, 1, TD, 1, 0, 0, 0);
    applyStimulus(0, TN, 1, TT, 1, 0, 0, 0);
    checkOutput("stray_tail", 5'b00000, 1'b0, 1'b0);
    applyStimulus(1, TH, 1, TH, 1, 0, 0, 0);
    applyStimulus(1, TH, 1, TH, 1, 1, 0, 0);
    applyStimulus(1, TD, 1, TH, 1, 1, 0, 0);
    applyStimulus(1, TT, 1, TH, 1, 1, 0, 0);
    applyStimulus(0, TN, 1, TH, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TD, 1, 0, 1, 0);
    applyStimulus(0, TN, 1, TT, 1, 0, 1, 0);
    applyStimulus(0, TN, 0, TN, 1, 0, 0, 0);
    checkOutput("final_idle", 5'b00000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL missing_event cycle=%0d actual=none required g0=%0b g1=%0b",
               exp_q[0].cyc, exp_q[0].g0, exp_q[0].g1);
      void'(exp_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
